// File: rtl/hilo_acc_unit_pkg.sv
// Shared definitions for the HI/LO accumulate unit.
//   RstEnable   : reset assertion level (active-high for this block family)
//   ZeroWord    : 32-bit zero, reset value of HI/LO
//   WriteEnable : write-enable assertion level
//   state_e     : accumulate FSM states, built from the ST_*_ENC encodings
package hilo_acc_unit_pkg;

  localparam logic        RstEnable   = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_LO_ENC   = 2'd1;
  localparam logic [1:0] ST_HI_ENC   = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE_ENC,
    S_LO = ST_LO_ENC,
    S_HI = ST_HI_ENC
  } state_e;

endpackage

// File: rtl/hilo_acc_unit_addsub.sv
// DATA_W-bit add/subtract slice with carry-in/carry-out, shared by both phases.
//   a_i, b_i : operands
//   sub_i    : 1 = use ~b_i; the caller supplies cin_i = 1 for a full subtract
//   cin_i    : carry-in (carry, or no-borrow when subtracting)
//   sum_c    : combinational result
//   cout_c   : combinational carry-out (no-borrow when subtracting)
module hilo_addsub_half #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  logic [W-1:0] b_eff;
  logic [W:0]   full_c;

  assign b_eff  = sub_i ? ~b_i : b_i;
  assign full_c = {1'b0, a_i} + {1'b0, b_eff} + (W+1)'(cin_i);
  assign sum_c  = full_c[W-1:0];
  assign cout_c = full_c[W];

endmodule

// File: rtl/hilo_acc_unit.sv
// HI/LO special registers with direct writes, same-cycle forwarding, and a
// two-phase multiply-accumulate engine (low half, then high half).
//   clk, rst            : clock, async active-high reset
//   hi_we/lo_we, hi_i/lo_i : direct writes
//   acc_valid/acc_ready : accumulate handshake; acc_sub selects subtract
//   acc_prod            : 2*DATA_W product
//   flush               : aborts an accumulate in progress
//   acc_done            : one-cycle pulse after commit
//   stall_o             : engine busy
//   hi_o/lo_o           : registered HI/LO
//   hi_fwd_o/lo_fwd_o   : write data when enabled, else registered value
module hilo_acc_unit
  import hilo_acc_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hi_we,
  input  logic                lo_we,
  input  logic [DATA_W-1:0]   hi_i,
  input  logic [DATA_W-1:0]   lo_i,
  input  logic                acc_valid,
  input  logic                acc_sub,
  input  logic [2*DATA_W-1:0] acc_prod,
  input  logic                flush,
  output logic                acc_ready,
  output logic                acc_done,
  output logic                stall_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic [DATA_W-1:0]   hi_fwd_o,
  output logic [DATA_W-1:0]   lo_fwd_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [PROD_W-1:0]   base_q, base_d;
  logic                sub_q, sub_d;
  logic [DATA_W-1:0]   lo_sum_q, lo_sum_d;
  logic                carry_q, carry_d;
  logic                done_q, done_d;

  logic                dir_wr;
  logic                in_hi;
  logic [DATA_W-1:0]   add_a, add_b, add_sum_c;
  logic                add_cin, add_cout_c;

  assign hi_fwd_o  = (hi_we == WriteEnable) ? hi_i : hi_q;
  assign lo_fwd_o  = (lo_we == WriteEnable) ? lo_i : lo_q;
  assign hi_o      = hi_q;
  assign lo_o      = lo_q;
  assign acc_done  = done_q;
  assign acc_ready = (state_q == IDLE);
  assign stall_o   = (state_q != IDLE);

  assign dir_wr = (hi_we == WriteEnable) || (lo_we == WriteEnable);
  assign in_hi  = (state_q == S_HI);

  // One adder serves both phases; the low phase seeds cin with sub so that
  // subtraction becomes base + ~prod + 1 across the full 2*DATA_W width.
  assign add_a   = in_hi ? base_q[PROD_W-1:DATA_W] : base_q[DATA_W-1:0];
  assign add_b   = in_hi ? prod_q[PROD_W-1:DATA_W] : prod_q[DATA_W-1:0];
  assign add_cin = in_hi ? carry_q : sub_q;

  hilo_addsub_half #(.W(DATA_W)) u_addsub (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (sub_q),
    .cin_i  (add_cin),
    .sum_c  (add_sum_c),
    .cout_c (add_cout_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod_d   = prod_q;
    base_d   = base_q;
    sub_d    = sub_q;
    lo_sum_d = lo_sum_q;
    carry_d  = carry_q;
    done_d   = 1'b0;

    if (hi_we == WriteEnable) hi_d = hi_i;
    if (lo_we == WriteEnable) lo_d = lo_i;

    unique case (state_q)
      IDLE: begin
        if (acc_valid && !flush) begin
          prod_d  = acc_prod;
          sub_d   = acc_sub;
          base_d  = {hi_fwd_o, lo_fwd_o};
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (flush || dir_wr) begin
          state_d = IDLE;
        end else begin
          lo_sum_d = add_sum_c;
          carry_d  = add_cout_c;
          state_d  = S_HI;
        end
      end
      S_HI: begin
        // Any direct write outranks the commit and abandons the accumulate.
        if (flush || dir_wr) begin
          state_d = IDLE;
        end else begin
          hi_d    = add_sum_c;
          lo_d    = lo_sum_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state_q  <= IDLE;
      hi_q     <= DATA_W'(ZeroWord);
      lo_q     <= DATA_W'(ZeroWord);
      prod_q   <= '0;
      base_q   <= '0;
      sub_q    <= 1'b0;
      lo_sum_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      prod_q   <= prod_d;
      base_q   <= base_d;
      sub_q    <= sub_d;
      lo_sum_q <= lo_sum_d;
      carry_q  <= carry_d;
      done_q   <= done_d;
    end
  end

endmodule
